// File: rtl/fir_mc_pkg.sv
// Shared types and helpers for the multi-channel decimating FIR lane.
package fir_mc_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_MAC,
    ST_ROUND,
    ST_OUT
  } state_e;

  // Channel index width; a single-channel lane still carries a 1-bit channel.
  function automatic int chw_of(input int ch_num);
    return (ch_num > 1) ? $clog2(ch_num) : 1;
  endfunction

  function automatic int coef_aw(input int ch_num, input int pcmaw, input int per_ch);
    return (per_ch != 0) ? chw_of(ch_num) + pcmaw : pcmaw;
  endfunction

  // Round half up by sh bits, then clamp to a signed dw-bit range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input logic [4:0] sh,
                                                   input int unsigned dw);
    logic signed [63:0] r;
    logic signed [63:0] lim;
    r = acc;
    if (sh != 5'd0) r = (acc + (64'sd1 <<< (sh - 5'd1))) >>> sh;
    lim = 64'sd1 <<< (dw - 1);
    if (r > lim - 64'sd1) r = lim - 64'sd1;
    else if (r < -lim)    r = -lim;
    return r;
  endfunction

endpackage

// File: rtl/fir_mc_mac.sv
// Multiply-accumulate pipe: RAM-data stage, product register, accumulator.
module fir_mc_mac #(
  parameter int DW  = 16,
  parameter int CW  = 16,
  parameter int ACW = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic signed [DW-1:0]  sample,
  input  logic signed [CW-1:0]  coef,
  output logic signed [ACW-1:0] acc,
  output logic                  done
);

  logic                    v2, l2, v3, l3;
  logic signed [DW+CW-1:0] prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      l2   <= 1'b0;
      v3   <= 1'b0;
      l3   <= 1'b0;
      prod <= '0;
      acc  <= '0;
      done <= 1'b0;
    end else if (clr) begin
      v2   <= 1'b0;
      l2   <= 1'b0;
      v3   <= 1'b0;
      l3   <= 1'b0;
      acc  <= '0;
      done <= 1'b0;
    end else begin
      // in_valid tags the address cycle; RAM data is valid one cycle later.
      v2   <= in_valid;
      l2   <= in_last;
      v3   <= v2;
      l3   <= l2;
      prod <= sample * coef;
      done <= v3 && l3;
      if (start)   acc <= '0;
      else if (v3) acc <= acc + ACW'(prod);
    end
  end

endmodule

// File: rtl/sdp_ram.sv
// Generic simple dual-port RAM: one write port, one registered read port.
module sdp_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [1 << AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fir_mc_lane.sv
// Time-multiplexed multi-channel decimating FIR lane with a valid/ready result stream.
module fir_mc_lane
  import fir_mc_pkg::*;
#(
  parameter int CH_NUM      = 4,
  parameter int DW          = 16,
  parameter int CW          = 16,
  parameter int ACW         = 40,
  parameter int PCMAW       = 8,
  parameter int TAPW        = 12,
  parameter int COEF_PER_CH = 0
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             clr,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic signed [DW-1:0]                             in_data,
  input  logic [chw_of(CH_NUM)-1:0]                        in_ch,
  input  logic [TAPW-1:0]                                  tap_len,
  input  logic [7:0]                                       decim,
  input  logic [4:0]                                       out_shift,
  output logic [coef_aw(CH_NUM, PCMAW, COEF_PER_CH)-1:0]   coef_addr,
  input  logic signed [CW-1:0]                             coef_q,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic signed [DW-1:0]                             out_data,
  output logic [chw_of(CH_NUM)-1:0]                        out_ch,
  output logic                                             busy
);

  localparam int CHW = chw_of(CH_NUM);
  localparam int CAW = coef_aw(CH_NUM, PCMAW, COEF_PER_CH);
  localparam int HAW = CHW + PCMAW;
  localparam int D   = 1 << PCMAW;
  localparam logic [HAW-1:0] CLR_LAST = HAW'(CH_NUM * D - 1);

  state_e state_q, state_d;

  logic [HAW-1:0]         clr_cnt;
  logic [PCMAW-1:0]       wr_ptr    [CH_NUM];
  logic [7:0]             decim_cnt [CH_NUM];
  logic [CHW-1:0]         ch, job_ch;
  logic [PCMAW-1:0]       job_newest, job_last, k, n_last;
  logic [4:0]             job_sh;
  logic                   issuing, iss_v, iss_last;
  logic                   accept, fire, tap_zero;
  logic [7:0]             dm1;
  logic [CAW-1:0]         coef_nxt;
  logic                   hist_we;
  logic [HAW-1:0]         hist_waddr, hist_raddr;
  logic signed [DW-1:0]   hist_wdata, hist_q;
  logic signed [ACW-1:0]  mac_acc;
  logic                   mac_done;

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_OUT);

  always_comb begin
    ch       = (CH_NUM == 1) ? '0 : in_ch;
    accept   = in_valid && in_ready;
    dm1      = (decim == 8'd0) ? 8'd0 : decim - 8'd1;
    fire     = (decim_cnt[ch] >= dm1);
    tap_zero = (tap_len == '0);
    n_last   = (32'(tap_len) >= D) ? '1 : PCMAW'(tap_len - TAPW'(1));
  end

  generate
    if (COEF_PER_CH != 0) begin : g_coef_per_ch
      assign coef_nxt = {job_ch, k};
    end else begin : g_coef_shared
      assign coef_nxt = k;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_CLEAR;
    else        state_q <= state_d;
  end

  // A zero-tap job passes through ROUND with the freshly cleared accumulator.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_cnt == CLR_LAST) state_d = ST_IDLE;
      ST_IDLE:  if (accept && fire) state_d = tap_zero ? ST_ROUND : ST_MAC;
      ST_MAC:   if (mac_done) state_d = ST_ROUND;
      ST_ROUND: state_d = ST_OUT;
      ST_OUT:   if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_CLEAR;
    endcase
    if (clr) state_d = ST_CLEAR;
  end

  always_comb begin
    hist_we    = 1'b0;
    hist_waddr = clr_cnt;
    hist_wdata = '0;
    if (state_q == ST_CLEAR) begin
      hist_we = 1'b1;
    end else if (accept) begin
      hist_we    = 1'b1;
      hist_waddr = {ch, wr_ptr[ch]};
      hist_wdata = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt <= '0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        wr_ptr[i]    <= '0;
        decim_cnt[i] <= '0;
      end
      job_ch     <= '0;
      job_newest <= '0;
      job_last   <= '0;
      job_sh     <= '0;
      k          <= '0;
      issuing    <= 1'b0;
      iss_v      <= 1'b0;
      iss_last   <= 1'b0;
      hist_raddr <= '0;
      coef_addr  <= '0;
      out_data   <= '0;
      out_ch     <= '0;
    end else if (clr) begin
      clr_cnt <= '0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        wr_ptr[i]    <= '0;
        decim_cnt[i] <= '0;
      end
      issuing  <= 1'b0;
      iss_v    <= 1'b0;
      iss_last <= 1'b0;
    end else begin
      iss_v    <= 1'b0;
      iss_last <= 1'b0;
      if (state_q == ST_CLEAR) clr_cnt <= (clr_cnt == CLR_LAST) ? '0 : clr_cnt + 1'b1;
      if (accept) begin
        wr_ptr[ch]    <= wr_ptr[ch] + 1'b1;
        decim_cnt[ch] <= fire ? 8'd0 : decim_cnt[ch] + 8'd1;
        if (fire) begin
          // Newest sample sits at the pre-increment pointer; tap k reads newest-k.
          job_ch     <= ch;
          job_newest <= wr_ptr[ch];
          job_last   <= n_last;
          job_sh     <= out_shift;
          k          <= '0;
          issuing    <= !tap_zero;
        end
      end
      if (issuing) begin
        coef_addr  <= coef_nxt;
        hist_raddr <= {job_ch, job_newest - k};
        iss_v      <= 1'b1;
        iss_last   <= (k == job_last);
        k          <= k + 1'b1;
        if (k == job_last) issuing <= 1'b0;
      end
      if (state_q == ST_ROUND) begin
        out_data <= DW'(round_sat(64'(mac_acc), job_sh, DW));
        out_ch   <= job_ch;
      end
    end
  end

  sdp_ram #(
    .AW(HAW),
    .DW(DW)
  ) u_hist (
    .clk  (clk),
    .we   (hist_we),
    .waddr(hist_waddr),
    .wdata(hist_wdata),
    .raddr(hist_raddr),
    .rdata(hist_q)
  );

  fir_mc_mac #(
    .DW (DW),
    .CW (CW),
    .ACW(ACW)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .start   (accept && fire),
    .in_valid(iss_v),
    .in_last (iss_last),
    .sample  (hist_q),
    .coef    (coef_q),
    .acc     (mac_acc),
    .done    (mac_done)
  );

endmodule

// File: tb/tb_fir_mc_lane.sv
// Directed self-checking bench for fir_mc_lane (shared and per-channel coefficient builds).
module tb_fir_mc_lane;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [15:0] in_data = '0;
  logic [1:0]  in_ch = '0;
  logic [11:0] tap_len = 12'd8;
  logic [7:0]  decim = 8'd1;
  logic [4:0]  out_shift = 5'd0;

  logic [7:0]  coef_addr;
  logic [9:0]  coef_addr2;
  logic signed [15:0] coef_q, coef_q2;
  logic in_ready, out_valid, busy, in_ready2, out_valid2, busy2;
  logic signed [15:0] out_data, out_data2;
  logic [1:0] out_ch, out_ch2;

  logic signed [15:0] coef_mem [256];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    coef_q  <= coef_mem[coef_addr];
    coef_q2 <= coef_mem[coef_addr2[7:0]];
  end

  fir_mc_lane u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ch(in_ch), .tap_len(tap_len), .decim(decim),
    .out_shift(out_shift), .coef_addr(coef_addr), .coef_q(coef_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .busy(busy)
  );

  fir_mc_lane #(.COEF_PER_CH(1)) u_pc (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_ch(in_ch), .tap_len(tap_len), .decim(decim),
    .out_shift(out_shift), .coef_addr(coef_addr2), .coef_q(coef_q2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_ch(out_ch2), .busy(busy2)
  );

  task automatic send(input logic signed [15:0] d, input logic [1:0] ch);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_ready: in_ready=%0b required 1 within 3000 cycles", in_ready);
    end else begin
      in_data  = d;
      in_ch    = ch;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  // Called right after an accepting edge; lat counts edges to out_valid.
  task automatic expect_out(input string name, input logic signed [15:0] d,
                            input logic [1:0] ch, input int lat, input int hold, input int ca);
    int n = 0;
    logic ok;
    logic signed [15:0] held;
    while (!out_valid && n < 400) begin
      @(posedge clk);
      #1 n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=0 required 1 within 400 cycles", name);
      return;
    end
    checks++;
    if (out_data !== d) begin
      errors++;
      $display("FAIL %s_data: got %0d required %0d", name, out_data, d);
    end
    checks++;
    if (out_ch !== ch) begin
      errors++;
      $display("FAIL %s_ch: got %0d required %0d", name, out_ch, ch);
    end
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d required %0d", name, n, lat);
    end
    checks++;
    if (out_valid2 !== 1'b1 || out_data2 !== d || out_ch2 !== ch) begin
      errors++;
      $display("FAIL %s_perch_dut: valid=%0b data=%0d ch=%0d required 1/%0d/%0d",
               name, out_valid2, out_data2, out_ch2, d, ch);
    end
    if (ca >= 0) begin
      checks++;
      if (coef_addr !== 8'(ca) || coef_addr2 !== 10'(ca)) begin
        errors++;
        $display("FAIL %s_coef_addr: got %0d/%0d required %0d/%0d",
                 name, coef_addr, coef_addr2, 8'(ca), 10'(ca));
      end
    end
    if (hold > 0) begin
      ok   = 1'b1;
      held = out_data;
      repeat (hold) begin
        @(posedge clk);
        #1;
        if (!out_valid || out_data !== held || in_ready) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s_hold: valid=%0b data=%0d in_ready=%0b required 1/%0d/0",
                 name, out_valid, out_data, in_ready, held);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drop: out_valid=%0b required 0 after handshake", name, out_valid);
    end
  endtask

  task automatic test_reset();
    int n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: in_ready=%0b out_valid=%0b busy=%0b required 0/0/1",
               in_ready, out_valid, busy);
    end
    checks++;
    if (out_data !== 16'sd0 || out_ch !== 2'd0 || coef_addr !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: out_data=%0d out_ch=%0d coef_addr=%0d required 0/0/0",
               out_data, out_ch, coef_addr);
    end
    rst_n = 1'b1;
    while (!in_ready && n < 1100) begin
      @(posedge clk);
      #1 n++;
    end
    checks++;
    if (n != 1024) begin
      errors++;
      $display("FAIL reset_clear_len: got %0d cycles required 1024", n);
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: out_valid=%0b busy=%0b required 0/0", out_valid, busy);
    end
  endtask

  task automatic test_impulse();
    tap_len = 12'd8; decim = 8'd1; out_shift = 5'd0;
    send(16'sd1, 2'd0);
    expect_out("imp0", 16'sd1, 2'd0, 13, 0, 7);
    for (int j = 1; j <= 8; j++) begin
      send(16'sd0, 2'd0);
      expect_out("imp", (j < 8) ? 16'(j + 1) : 16'sd0, 2'd0, 13, 0, 7);
    end
  endtask

  task automatic test_round_sat();
    tap_len = 12'd1; out_shift = 5'd13;
    send(16'sd4096, 2'd0);
    expect_out("rnd_half", 16'sd1, 2'd0, 6, 0, 0);
    send(16'sd4095, 2'd0);
    expect_out("rnd_below", 16'sd0, 2'd0, 6, 0, 0);
    coef_mem[0] = -16'sd32768;
    send(-16'sd32768, 2'd0);
    expect_out("sat_pos", 16'sd32767, 2'd0, 6, 0, 0);
    tap_len = 12'd2; coef_mem[1] = -16'sd32768;
    send(16'sd16384, 2'd0);
    expect_out("sat_pos2", 16'sd32767, 2'd0, 7, 0, 1);
    send(16'sd16384, 2'd0);
    expect_out("sat_neg", -16'sd32768, 2'd0, 7, 0, 1);
    coef_mem[0] = 16'sd1; coef_mem[1] = 16'sd2; tap_len = 12'd1;
    send(-16'sd4096, 2'd0);
    expect_out("rnd_neg_half", 16'sd0, 2'd0, 6, 0, 0);
    send(-16'sd4097, 2'd0);
    expect_out("rnd_neg", -16'sd1, 2'd0, 6, 0, 0);
    out_shift = 5'd1;
    send(16'sd3, 2'd0);
    expect_out("rnd_sh1", 16'sd2, 2'd0, 6, 0, 0);
    out_shift = 5'd0;
  endtask

  task automatic test_decim_interleave();
    int spurious = 0;
    decim = 8'd2; tap_len = 12'd1;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 2; c++) begin
        send(16'((c == 0 ? 100 : 200) + i), 2'(c));
        if (i % 2 == 1) begin
          expect_out("decim", 16'((c == 0 ? 100 : 200) + i), 2'(c), 6,
                     (i == 1 && c == 0) ? 20 : 0, -1);
        end else begin
          repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) spurious++;
          end
        end
      end
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL decim_spurious: got %0d extra valid cycles required 0", spurious);
    end
    decim = 8'd1;
  endtask

  task automatic test_tap_zero();
    tap_len = 12'd0;
    send(16'sd1234, 2'd2);
    expect_out("tap0", 16'sd0, 2'd2, 1, 0, -1);
    out_shift = 5'd5;
    send(-16'sd999, 2'd1);
    expect_out("tap0_sh", 16'sd0, 2'd1, 1, 0, -1);
    out_shift = 5'd0;
  endtask

  task automatic test_long_taps();
    tap_len = 12'd300;
    send(16'sd1, 2'd3);
    expect_out("long", 16'sd1, 2'd3, 261, 0, 1023);
  endtask

  task automatic test_clr_abort();
    int n = 0;
    logic seen = 1'b0;
    tap_len = 12'd8;
    send(16'sd5, 2'd0);
    repeat (4) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    while (!in_ready && n < 1100) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk);
      #1 n++;
    end
    checks++;
    if (n != 1024) begin
      errors++;
      $display("FAIL clr_clear_len: got %0d cycles required 1024", n);
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL clr_abort: out_valid seen=%0b required 0", seen);
    end
    send(16'sd1, 2'd0);
    expect_out("clr_imp0", 16'sd1, 2'd0, 13, 0, 7);
    send(16'sd0, 2'd0);
    expect_out("clr_imp1", 16'sd2, 2'd0, 13, 0, 7);
    send(16'sd0, 2'd0);
    expect_out("clr_imp2", 16'sd3, 2'd0, 13, 0, 7);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) coef_mem[i] = 16'(i + 1);
    test_reset();
    test_impulse();
    test_round_sat();
    test_decim_interleave();
    test_tap_zero();
    test_long_taps();
    test_clr_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_mc_lane.md
Name: fir_mc_lane

Overview:
- Time-multiplexed multi-channel decimating FIR lane; successor to the single-channel fir_lane.
- Holds a per-channel circular sample history and runs one MAC per output.
- Coefficients come from an external synchronous param RAM, and results are emitted through a valid/ready stream.
- Sits between the per-channel PCM capture stage and the beamform/summing stage, in a single clock domain.

Parameters:
CH_NUM, 4, number of channels (power of 2, >=1)
DW, 16, signed sample and output width
CW, 16, signed coefficient width
ACW, 40, accumulator width (>= DW+CW+PCMAW)
PCMAW, 8, log2 history depth per channel (depth D = 2^PCMAW)
TAPW, 12, tap_len width
COEF_PER_CH, 0, 1 = coef_addr = {ch, tap}; 0 = {tap} shared by all channels

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  sync pulse: flush all history and counters
in_valid  in  1  input sample valid
in_ready  out  1  lane accepts sample
in_data  in  DW  signed PCM sample
in_ch  in  log2(CH_NUM) (min 1)  channel of sample
tap_len  in  TAPW  taps per output
decim  in  8  decimation ratio
out_shift  in  5  right shift applied to accumulator
coef_addr  out  PCMAW(+log2 CH_NUM if COEF_PER_CH)  param RAM address
coef_q  in  CW  param RAM data, 1-cycle read latency
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_data  out  DW  signed rounded/saturated result
out_ch  out  log2(CH_NUM)  channel of result
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, out_ch=0, coef_addr=0, busy=1. All wr_ptr and decim_cnt = 0. FSM enters CLEAR.
- CLEAR: writes 0 to every history word, one word per cycle (CH_NUM*D cycles), then goes to IDLE. A clr pulse in any state aborts the current job, drops out_valid and re-enters CLEAR.
- IDLE: in_ready=1. On in_valid&in_ready:
  - write in_data to hist[in_ch][wr_ptr[in_ch]]; wr_ptr wraps modulo D.
  - decim_cnt[in_ch]++. When it reaches max(decim,1)-1, reset it to 0 and go to MAC; otherwise stay in IDLE.
- Job snapshot at MAC entry: ch, base = new wr_ptr[ch], N = min(tap_len, D), sh = out_shift. Config changes mid-job have no effect.
- N==0: skip MAC; result = 0, go to OUT.
- MAC: k = 0..N-1, one tap per cycle.
  - Each cycle issues coef_addr = k (or {ch,k}) and hist address base-1-k mod D.
  - 3-stage pipe: address, RAM data, product register. acc += sample*coef, signed full-precision, sign-extended to ACW.
  - Last product lands N+3 cycles after MAC entry; then go to ROUND.
- ROUND (1 cycle):
  - if sh>0, r = (acc + 2^(sh-1)) >>> sh (arithmetic shift); if sh==0, r = acc.
  - saturate r to [-2^(DW-1), 2^(DW-1)-1].
  - go to OUT.
- OUT: out_valid=1; out_data/out_ch are stable until out_ready. On handshake: out_valid=0, go to IDLE.
- in_ready is 0 in every state except IDLE, so no history write races a MAC.
- Latency, input accept to out_valid: N+5 cycles. For N==0: 1 cycle.
- decim==0 is treated as 1; decim_cnt is per channel, so interleaved channels decimate independently.
- History RAM is simple dual-port (write port shared by CLEAR and input; read port used by MAC). Read-during-write is impossible by construction.

Decomposition:
- Package fir_mc_pkg holds: FSM state enum (CLEAR, IDLE, MAC, ROUND, OUT), CHW = max(1, clog2(CH_NUM)), the rounding/saturation function, and coef address width.
- One natural sub-module: fir_mc_mac, the 3-stage multiply-accumulate pipe with clear/enable/done.
- History RAM uses the existing generic dual-port RAM.

Test Plan:
- Reset release: busy=1 for exactly CH_NUM*D cycles (1024 at defaults), in_ready=0 throughout, then in_ready=1, out_valid=0.
- Impulse, ch0, tap_len=8, decim=1, out_shift=0, coef k = k+1, input 1 then 0s: outputs 1,2,…,8, then 0; each out_valid exactly 13 cycles after accept.
- Rounding/saturation, out_shift=13: acc=4096 gives 1 (round half up); acc=2^30 gives 32767; acc=-2^30 gives -32768.
- decim=2, ch0/ch1 samples interleaved (10 each): exactly 5 outputs per channel, out_ch correct. Hold out_ready=0 for 20 cycles: out_data stable, in_ready=0.
- tap_len=0 gives 0 one cycle after accept. tap_len=300 with D=256 behaves as N=256 (latency 261). COEF_PER_CH=1: coef_addr upper bits equal ch.
- clr pulse mid-MAC: out_valid never asserts for that job; CLEAR runs for 1024 cycles; the next impulse reproduces the coefficients with no stale history.
